fetch_prefetch_unit: RTL
========================

Name: fetch_prefetch_unit

Overview:
- Instruction-fetch front end of the pipelined RISC-V core.
- Owns the fetch PC and drives the instruction ROM address.
- Absorbs the ROM's 1-cycle read latency and buffers fetched instructions in a small queue.
- Presents {PC, instruction} pairs to the IF/ID register with a valid/ready handshake. A branch redirect from EX flushes all buffered and in-flight fetches.

Parameters:
- DEPTH, 4, prefetch queue entries; power of 2, minimum 2.
- ADDR_W, 10, word-address width of the instruction ROM.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.

Ports:
- CLK  input  1  core clock, rising edge.
- RESET_N  input  1  reset, asynchronous, active-low.
- DATA_IMEM  input  32  ROM read data; valid 1 cycle after the address is issued.
- DIR_IMEM  output  ADDR_W  ROM word address = fetch_pc[ADDR_W+1:2].
- IMEM_REQ  output  1  high in cycles where DIR_IMEM is a real fetch that will be captured.
- REDIRECT  input  1  taken branch/jump from EX; flush and refetch.
- REDIRECT_PC  input  32  redirect target; bits [1:0] ignored (forced 0).
- INST_VALID  output  1  queue head holds a valid instruction.
- INST_OUT  output  32  queue head instruction.
- INST_PC  output  32  byte PC of INST_OUT.
- INST_READY  input  1  IF/ID register accepts the head (low = hazard-unit stall).

Behaviour:
- Reset values (asynchronous):
  - fetch_pc = RESET_PC; queue empty; in-flight flag = 0.
  - INST_VALID = 0; INST_OUT = 0; INST_PC = 0; IMEM_REQ = 0.
  - DIR_IMEM = RESET_PC[ADDR_W+1:2].
- Reset asserted mid-operation discards everything immediately. First IMEM_REQ occurs in the first cycle after RESET_N deasserts.
- Issue rule: IMEM_REQ = !REDIRECT && (count + inflight) < DEPTH.
  - On issue: fetch_pc += 4; inflight <= 1; inflight_pc <= fetch_pc.
  - Without issue: fetch_pc holds and inflight <= 0.
- Capture: when inflight = 1 and no REDIRECT, push {inflight_pc, DATA_IMEM} into the queue in the same cycle.
- Credit accounting: counting in-flight requests guarantees a push never meets a full queue. No drop path exists.
- Pop: INST_VALID && INST_READY removes the head at the clock edge.
- Simultaneous push and pop are allowed. Count holds, including at full and at empty.
- Output timing: INST_OUT and INST_PC are registered queue-head values; there is no combinational ROM-to-output path.
  - Latency from issue to INST_VALID: 2 cycles (ROM cycle, then push).
- Steady state with INST_READY = 1: one instruction delivered per cycle.
- Redirect (highest priority) at the clock edge:
  - Queue cleared; inflight cleared, so the response arriving next cycle is dropped.
  - fetch_pc <= {REDIRECT_PC[31:2], 2'b00}.
  - Any pop or push in that cycle is discarded.
  - Next cycle: IMEM_REQ = 1 at the target. Target instruction reaches INST_VALID 2 cycles after that.
- Back-to-back REDIRECT: each flushes again. The last target wins.
- Wrap-around:
  - fetch_pc wraps modulo 2^32.
  - DIR_IMEM truncates to ADDR_W bits, so the ROM aliases. This is intentional and not flagged.
  - Queue pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- Stall (INST_READY = 0): queue fills to DEPTH, then IMEM_REQ drops. fetch_pc points to the next unfetched word.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds output ports:
  - FETCH_DELIVERED_CNT [31:0]: increments per pop.
  - FETCH_FLUSHED_CNT [31:0]: increments on REDIRECT by (count + inflight).
  - Both reset to 0 and wrap.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg:
  - ADDR_W default constant.
  - RESET_PC constant.
  - fetch_entry_t typedef (struct {pc[31:0], inst[31:0]}).
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t, parameter DEPTH, with push/pop/flush/count.
  - Flush has priority over push and pop.
- The top level holds the PC, the in-flight tracking and the redirect priority.

Test Plan:
- Reset, ROM word n = 32'h1000_0000+n, INST_READY = 1 → first INST_VALID 2 cycles after RESET_N rises. Pairs (0,10000000), (4,10000001), (8,10000002) delivered on consecutive cycles.
- INST_READY = 0 for 10 cycles → count reaches 4; IMEM_REQ low once count + inflight = 4; fetch_pc = 16. On release, PCs 0,4,8,12,16 are delivered in order with no gap or duplicate.
- REDIRECT with REDIRECT_PC = 32'h40 while the queue holds 3 entries and 1 is in flight → INST_VALID low next cycle; DIR_IMEM = 16. Next valid pair is (40, ROM[16]); the stale in-flight response is never delivered.
- REDIRECT with REDIRECT_PC = 32'h23 → fetch resumes at 32'h20; INST_PC = 32'h20.
- REDIRECT in the same cycle as a pop and a push → both discarded; count = 0 after the edge. Two consecutive REDIRECTs (0x80, then 0xC0) → only 0xC0-sequence instructions appear.
- Assert RESET_N low with the queue full mid-stream → all outputs return to reset values immediately and fetch restarts at RESET_PC. With FETCH_PERF_EN, counters read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// Provides the ROM address width, reset PC and the queue entry type.
package fetch_pkg;

    localparam int          ADDR_W_DEF   = 10;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, inst} entries; flush beats push and pop.
// Ports: CLK, RESET_N, flush, push, push_data, pop, head, head_valid, count.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic                       head_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           do_pop;
    logic           do_push;

    assign do_pop  = pop && (count != '0);
    // A push into a full queue is only legal when the head leaves too.
    assign do_push = push && ((count < CW'(DEPTH)) || do_pop);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    // Storage is not reset, so an empty queue presents zeros.
    assign head_valid = (count != '0);
    assign head       = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: owns fetch PC, hides ROM latency, queues instructions.
// Ports: CLK, RESET_N, DATA_IMEM, DIR_IMEM, IMEM_REQ, REDIRECT, REDIRECT_PC,
// INST_VALID, INST_OUT, INST_PC, INST_READY; FETCH_PERF_EN adds
// FETCH_DELIVERED_CNT and FETCH_FLUSHED_CNT.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [31:0]       DATA_IMEM,
    output logic [ADDR_W-1:0] DIR_IMEM,
    output logic              IMEM_REQ,
    input  logic              REDIRECT,
    input  logic [31:0]       REDIRECT_PC,
    output logic              INST_VALID,
    output logic [31:0]       INST_OUT,
    output logic [31:0]       INST_PC,
    input  logic              INST_READY
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       FETCH_DELIVERED_CNT,
    output logic [31:0]       FETCH_FLUSHED_CNT
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [CW-1:0] q_count;
    logic [CW-1:0] occ;
    logic          issue;
    logic          push;
    logic          pop;
    fetch_entry_t  push_data;
    fetch_entry_t  head;
    logic          unused_ok;

    assign unused_ok = ^REDIRECT_PC[1:0];

    // Counting the in-flight request as occupied means a response
    // always finds room when it arrives.
    assign occ      = q_count + CW'(inflight);
    assign issue    = RESET_N && !REDIRECT && (occ < CW'(DEPTH));
    assign IMEM_REQ = issue;
    assign DIR_IMEM = fetch_pc[ADDR_W+1:2];

    assign push      = inflight && !REDIRECT;
    assign pop       = INST_VALID && INST_READY;
    assign push_data = '{pc: inflight_pc, inst: DATA_IMEM};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (REDIRECT) begin
            fetch_pc <= {REDIRECT_PC[31:2], 2'b00};
            inflight <= 1'b0;
        end else if (issue) begin
            fetch_pc    <= fetch_pc + 32'd4;
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
        end else begin
            inflight <= 1'b0;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .flush      (REDIRECT),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head       (head),
        .head_valid (INST_VALID),
        .count      (q_count)
    );

    assign INST_OUT = head.inst;
    assign INST_PC  = head.pc;

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            FETCH_DELIVERED_CNT <= '0;
            FETCH_FLUSHED_CNT   <= '0;
        end else if (REDIRECT) begin
            FETCH_FLUSHED_CNT <= FETCH_FLUSHED_CNT + 32'(occ);
        end else if (pop) begin
            FETCH_DELIVERED_CNT <= FETCH_DELIVERED_CNT + 32'd1;
        end
    end
`endif

endmodule
